// File: rtl/sc_add_decoder_if.sv
// Handshake bundle for the stochastic-computing add decoder.
// master drives start/abort/samples; slave reports busy/done/results.
interface sc_add_decoder_if #(
  parameter int WLOG    = 8,
  parameter int LOGINUM = 4
);
  logic                      start;
  logic                      abort;
  logic                      in_bit;
  logic                      in_valid;
  logic                      busy;
  logic                      done;
  logic [WLOG:0]             cnt_out;
  logic [WLOG+LOGINUM:0]     sum_out;

  modport master (
    output start, abort, in_bit, in_valid,
    input  busy, done, cnt_out, sum_out
  );

  modport slave (
    input  start, abort, in_bit, in_valid,
    output busy, done, cnt_out, sum_out
  );
endinterface

// File: rtl/sc_add_decoder.sv
// Counts ones over a 2^WLOG valid-sample window of a mux-adder bitstream
// and rescales the count by 2^LOGINUM. Ports: clk, rst_n, bus (slave).
module sc_add_decoder #(
  parameter int WLOG    = 8,
  parameter int LOGINUM = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  sc_add_decoder_if.slave bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]      state_q, state_d;
  logic [WLOG-1:0] smp_q, smp_d;
  logic [WLOG:0]   ones_q, ones_d;
  logic [WLOG:0]   cnt_q, cnt_d;
  logic [WLOG:0]   ones_inc;
  logic            last_smp;
  logic            busy_q, done_q;

  assign ones_inc = ones_q + (WLOG+1)'(bus.in_bit);
  assign last_smp = (smp_q == '1);

  always_comb begin
    state_d = state_q;
    smp_d   = smp_q;
    ones_d  = ones_q;
    cnt_d   = cnt_q;
    unique case (1'b1)
      (state_q == S_RUN): begin
        // abort outranks both acceptance and completion
        if (bus.abort) begin
          state_d = S_IDLE;
        end else if (bus.in_valid) begin
          smp_d  = smp_q + WLOG'(1);
          ones_d = ones_inc;
          if (last_smp) begin
            state_d = S_DONE;
            cnt_d   = ones_inc;
          end
        end
      end
      (state_q == S_DONE): begin
        if (bus.start) begin
          state_d = S_RUN;
          smp_d   = '0;
          ones_d  = '0;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: begin
        // IDLE, and recovery from the unused encoding
        smp_d   = '0;
        ones_d  = '0;
        state_d = bus.start ? S_RUN : S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      smp_q   <= '0;
      ones_q  <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      smp_q   <= smp_d;
      ones_q  <= ones_d;
      cnt_q   <= cnt_d;
      busy_q  <= (state_d == S_RUN);
      done_q  <= (state_d == S_DONE);
    end
  end

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.cnt_out = cnt_q;
  assign bus.sum_out = {cnt_q, {LOGINUM{1'b0}}};

endmodule

// File: tb/tb_sc_add_decoder.sv
// Directed bench for sc_add_decoder (WLOG=8, LOGINUM=4).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_sc_add_decoder;

  localparam int WLOG    = 8;
  localparam int LOGINUM = 4;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  sc_add_decoder_if #(.WLOG(WLOG), .LOGINUM(LOGINUM)) bus ();

  sc_add_decoder #(.WLOG(WLOG), .LOGINUM(LOGINUM)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d", tag, obs, exp);
    end
  endtask

  task automatic idle_in();
    bus.start    = 1'b0;
    bus.abort    = 1'b0;
    bus.in_bit   = 1'b0;
    bus.in_valid = 1'b0;
  endtask

  // mode 0 all ones, 1 alternating 1/0, 2 all zeros,
  // 3 valid every other cycle with in_bit held at 1
  task automatic run_win(input int mode, output int busy_cyc);
    int k;
    busy_cyc = 0;
    k = 0;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    while (bus.busy && k < 2000) begin
      case (mode)
        0: begin bus.in_valid = 1'b1; bus.in_bit = 1'b1; end
        1: begin bus.in_valid = 1'b1; bus.in_bit = (k % 2 == 0); end
        2: begin bus.in_valid = 1'b1; bus.in_bit = 1'b0; end
        default: begin bus.in_valid = (k % 2 == 0); bus.in_bit = 1'b1; end
      endcase
      busy_cyc++;
      k++;
      @(negedge clk);
    end
    idle_in();
  endtask

  initial begin
    int bc;
    int cyc;
    int d0;
    int d1;
    checks = 0;
    errors = 0;
    idle_in();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_done", 32'(bus.done), 0);
    chk("rst_cnt", 32'(bus.cnt_out), 0);
    chk("rst_sum", 32'(bus.sum_out), 0);
    rst_n = 1'b1;
    bus.abort = 1'b1;
    bus.in_valid = 1'b1;
    repeat (3) @(negedge clk);
    idle_in();
    chk("idle_busy", 32'(bus.busy), 0);

    // all ones
    run_win(0, bc);
    chk("ones_busycyc", 32'(bc), 256);
    chk("ones_done", 32'(bus.done), 1);
    chk("ones_cnt", 32'(bus.cnt_out), 256);
    chk("ones_sum", 32'(bus.sum_out), 4096);
    @(negedge clk);
    chk("ones_done_pulse", 32'(bus.done), 0);
    chk("ones_hold", 32'(bus.cnt_out), 256);

    // all zeros
    run_win(2, bc);
    chk("zero_cnt", 32'(bus.cnt_out), 0);
    chk("zero_sum", 32'(bus.sum_out), 0);
    @(negedge clk);

    // valid every other cycle
    run_win(3, bc);
    chk("half_busycyc", 32'(bc), 511);
    chk("half_cnt", 32'(bus.cnt_out), 256);
    @(negedge clk);

    // alternating
    run_win(1, bc);
    chk("alt_done", 32'(bus.done), 1);
    chk("alt_cnt", 32'(bus.cnt_out), 128);
    chk("alt_sum", 32'(bus.sum_out), 2048);
    @(negedge clk);

    // abort at sample 100
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_bit = 1'b1;
    repeat (100) @(negedge clk);
    bus.abort = 1'b1;
    @(negedge clk);
    idle_in();
    chk("abort_busy", 32'(bus.busy), 0);
    chk("abort_done", 32'(bus.done), 0);
    chk("abort_cnt", 32'(bus.cnt_out), 128);
    @(negedge clk);
    chk("abort_done2", 32'(bus.done), 0);
    chk("abort_sum", 32'(bus.sum_out), 2048);

    // back-to-back with start held
    d0 = -1;
    d1 = -1;
    cyc = 0;
    bus.start = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_bit = 1'b1;
    while (d1 < 0 && cyc < 1000) begin
      @(negedge clk);
      cyc++;
      if (bus.done) begin
        if (d0 < 0) d0 = cyc;
        else d1 = cyc;
      end
    end
    idle_in();
    chk("b2b_gap", 32'(d1 - d0), 257);
    chk("b2b_cnt", 32'(bus.cnt_out), 256);
    @(negedge clk);
    chk("b2b_idle", 32'(bus.busy), 0);

    // reset mid-window at sample 50
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_bit = 1'b1;
    repeat (50) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mrst_busy", 32'(bus.busy), 0);
    chk("mrst_done", 32'(bus.done), 0);
    chk("mrst_cnt", 32'(bus.cnt_out), 0);
    chk("mrst_sum", 32'(bus.sum_out), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (300) @(negedge clk);
    chk("mrst_idle_busy", 32'(bus.busy), 0);
    chk("mrst_idle_done", 32'(bus.done), 0);
    chk("mrst_idle_cnt", 32'(bus.cnt_out), 0);
    idle_in();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sc_add_decoder.md
SC_ADD_DECODER -- requirements
Module: sc_add_decoder

Interface
REQ-001 SHALL have parameter WLOG, default 8, meaning log2 of the decode window length in valid samples (window N = 2^WLOG).
REQ-002 SHALL have parameter LOGINUM, default 4, meaning log2 of the mux-adder input count, used as the re-scaling shift.
REQ-003 SHALL have port clk  input  1  clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset; asynchronous, active-low.
REQ-005 SHALL have port start  input  1  request to begin a new decode window.
REQ-006 SHALL have port abort  input  1  cancels a running window.
REQ-007 SHALL have port in_bit  input  1  scaled-sum bitstream from the mux adder.
REQ-008 SHALL have port in_valid  input  1  qualifies in_bit as a sample.
REQ-009 SHALL have port busy  output  1  high while a window is being accumulated.
REQ-010 SHALL have port done  output  1  single-cycle pulse when a window completes.
REQ-011 SHALL have port cnt_out  output  WLOG+1  count of ones in the last completed window.
REQ-012 SHALL have port sum_out  output  WLOG+LOGINUM+1  re-scaled sum estimate of the last completed window.

Function
REQ-013 SHALL implement a three-state FSM: IDLE, RUN, DONE.
REQ-014 IDLE: start=1 -> RUN next cycle; sample and ones counters cleared on that transition.
REQ-015 RUN: each cycle with in_valid=1 -> sample counter +1; ones counter +1 if in_bit=1; in_valid=0 cycles leave both counters unchanged.
REQ-016 RUN: the cycle that accepts the N-th valid sample -> DONE next cycle.
REQ-017 RUN: abort=1 -> IDLE next cycle, that cycle's sample discarded, no done pulse, cnt_out/sum_out unchanged; abort takes priority over sample acceptance and completion.
REQ-018 RUN: start is ignored.
REQ-019 DONE: lasts exactly one cycle; done=1; cnt_out = final ones count (including the N-th sample); sum_out = cnt_out << LOGINUM (zero-filled, no truncation).
REQ-020 DONE: start=1 -> RUN next cycle with counters cleared (back-to-back windows); otherwise -> IDLE.
REQ-021 abort is ignored in IDLE and DONE.
REQ-022 busy SHALL be 1 exactly in RUN; done SHALL be 1 exactly in DONE; both registered outputs.
REQ-023 cnt_out and sum_out SHALL update only on entry to DONE and hold between completions.
REQ-024 Ones counter SHALL be WLOG+1 bits so an all-ones window yields exactly 2^WLOG without wrap.
REQ-025 Latency: start sampled at cycle t -> busy=1 at t+1; first sample accepted at t+1 at the earliest; N-th sample at cycle k -> done=1, busy=0 and new outputs at k+1.
REQ-026 Sample counter SHALL be WLOG bits wide and wrap to 0 only on the terminal sample.

Reset
REQ-027 rst_n=0 SHALL immediately force state IDLE, busy=0, done=0, cnt_out=0, sum_out=0, all counters 0, including mid-window.
REQ-028 After rst_n deassertion the block SHALL remain in IDLE until start=1.

Verification
REQ-029 WLOG=8, LOGINUM=4; start, then 256 consecutive valid ones -> busy 256 cycles, done one cycle later, cnt_out=256, sum_out=4096.
REQ-030 Alternating 1/0 with in_valid=1 for 256 samples -> cnt_out=128, sum_out=2048; all-zeros window -> cnt_out=0, sum_out=0.
REQ-031 in_valid high every other cycle, in_bit=1 throughout -> done after 511 RUN cycles, cnt_out=256; ones presented with in_valid=0 are not counted.
REQ-032 Previous window cnt_out=128; new window aborted at sample 100 -> IDLE next cycle, no done, cnt_out stays 128, busy=0.
REQ-033 start held high through DONE -> second window starts next cycle; two done pulses exactly 257 cycles apart with continuous valid input.
REQ-034 rst_n asserted at sample 50 of a window -> outputs immediately 0, no done; after release, idle until start.
